// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO write-side packet producer.
// State encoding, header tag and header-word builder.
package fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2
   } state_t;

   localparam logic [1:0] HDR_TAG = 2'b10;

   // Tag sits directly above the length field; callers size-cast to DSIZE.
   function automatic logic [31:0] hdr_word(input logic [31:0] len,
                                            input int unsigned lsize);
      logic [31:0] mask;
      mask = (32'd1 << lsize) - 32'd1;
      return (32'(HDR_TAG) << lsize) | (len & mask);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         wclk,
   input  logic         w_rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge wclk or negedge w_rst) begin
      if (!w_rst)
         cnt <= '0;
      else if (inc && !(&cnt))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/fifo_pkt_writer.sv
// Header + payload packet producer feeding an async FIFO write port.
// Length is authoritative; s_last only drives the framing-error flag.
module fifo_pkt_writer
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int CSIZE = 16
) (
   input  logic                wclk,
   input  logic                w_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [DSIZE-3:0]    cmd_len,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DSIZE-1:0]    s_data,
   input  logic                s_last,
   input  logic                full,
   output logic                winc,
   output logic [DSIZE-1:0]    wdata,
   output logic                busy,
   output logic                len_err,
   input  logic                err_clr,
   output logic [CSIZE-1:0]    pkt_cnt,
   output logic [CSIZE-1:0]    stall_cnt
);

   localparam int LSIZE = DSIZE - 2;

   state_t           state, nstate;
   logic [LSIZE-1:0] rem, rem_nxt;
   logic [DSIZE-1:0] hdr;
   logic             pkt_inc;
   logic             err_set;
   logic             stall;

   assign hdr  = DSIZE'(hdr_word(32'(rem), LSIZE));
   assign busy = (state != ST_IDLE);

   always_comb begin
      nstate    = state;
      rem_nxt   = rem;
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      winc      = 1'b0;
      wdata     = '0;
      pkt_inc   = 1'b0;
      err_set   = 1'b0;
      stall     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               rem_nxt = cmd_len;
               nstate  = ST_HDR;
            end
         end
         ST_HDR: begin
            if (full) begin
               stall = 1'b1;
            end else begin
               winc  = 1'b1;
               wdata = hdr;
               if (rem == '0) begin
                  nstate  = ST_IDLE;
                  pkt_inc = 1'b1;
               end else begin
                  nstate = ST_PAY;
               end
            end
         end
         ST_PAY: begin
            s_ready = !full;
            stall   = s_valid && full;
            if (s_valid && !full) begin
               winc    = 1'b1;
               wdata   = s_data;
               rem_nxt = rem - LSIZE'(1);
               // The final beat must carry s_last; any other beat must not.
               if (rem == LSIZE'(1)) begin
                  nstate  = ST_IDLE;
                  pkt_inc = 1'b1;
                  err_set = !s_last;
               end else begin
                  err_set = s_last;
               end
            end
         end
         default: nstate = ST_IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge w_rst) begin
      if (!w_rst) begin
         state   <= ST_IDLE;
         rem     <= '0;
         pkt_cnt <= '0;
         len_err <= 1'b0;
      end else begin
         state <= nstate;
         rem   <= rem_nxt;
         if (pkt_inc)
            pkt_cnt <= pkt_cnt + CSIZE'(1);
         if (err_clr)
            len_err <= 1'b0;
         else if (err_set)
            len_err <= 1'b1;
      end
   end

   sat_counter #(.W(CSIZE)) u_stall (
      .wclk  (wclk),
      .w_rst (w_rst),
      .inc   (stall),
      .cnt   (stall_cnt)
   );

endmodule
